// File: rtl/multimode_counter_pkg.sv
// Shared types and helpers for the multimode counter: mode encoding, seeds,
// Gray conversion and per-mode state legality. Values are zero-extended to 32 bits.
package multimode_counter_pkg;

  typedef enum logic [1:0] {
    JOHNSON = 2'd0,
    RING    = 2'd1,
    BINARY  = 2'd2,
    GRAY    = 2'd3
  } mode_e;

  function automatic logic [31:0] seed(mode_e m);
    return (m == RING) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] bin2gray(logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Johnson states have at most one 0/1 boundary inside the word; ring states are one-hot.
  function automatic logic is_legal(mode_e m, logic [31:0] v, int unsigned width);
    int unsigned cnt;
    cnt = 0;
    case (m)
      JOHNSON: begin
        for (int unsigned i = 0; i < 31; i++) begin
          if ((i + 1 < width) && (v[i+1] ^ v[i])) cnt++;
        end
        return (cnt <= 1);
      end
      RING: begin
        for (int unsigned i = 0; i < 32; i++) begin
          if ((i < width) && v[i]) cnt++;
        end
        return (cnt == 1);
      end
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/multimode_counter_gray_step.sv
// Combinational Gray-code increment/decrement for WIDTH bits.
module gray_step
  import multimode_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] nb;

  always_comb begin
    b   = WIDTH'(gray2bin(32'(q)));
    nb  = dir ? (b - WIDTH'(1)) : (b + WIDTH'(1));
    nxt = WIDTH'(bin2gray(32'(nb)));
  end

endmodule

// File: rtl/multimode_counter.sv
// Run-time selectable Johnson / ring / binary / Gray counter with direction,
// parallel load, illegal-state self-correction and a registered wrap pulse.
module multimode_counter
  import multimode_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             illegal
);

  mode_e            m;
  logic [WIDTH-1:0] seed_w;
  logic [WIDTH-1:0] gray_nxt;
  logic [WIDTH-1:0] nxt;
  logic             wrap_nxt;

  assign m       = mode_e'(mode);
  assign seed_w  = WIDTH'(seed(m));
  assign illegal = ~is_legal(m, 32'(q), WIDTH);

  gray_step #(.WIDTH(WIDTH)) u_gray_step (
    .q   (q),
    .dir (dir),
    .nxt (gray_nxt)
  );

  always_comb begin
    nxt = q;
    case (m)
      JOHNSON: nxt = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
      RING:    nxt = dir ? {q[0], q[WIDTH-1:1]}  : {q[WIDTH-2:0], q[WIDTH-1]};
      BINARY:  nxt = dir ? (q - WIDTH'(1)) : (q + WIDTH'(1));
      GRAY:    nxt = gray_nxt;
      default: nxt = q;
    endcase
  end

  // Down sequences wrap when leaving the seed, up sequences when arriving at it.
  assign wrap_nxt = dir ? (q == seed_w) : (nxt == seed_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= seed_w;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      if (illegal) begin
        q    <= seed_w;
        wrap <= 1'b0;
      end else begin
        q    <= nxt;
        wrap <= wrap_nxt;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multimode_counter.sv
// Scoreboard bench for multimode_counter (WIDTH=4) with directed vectors.
module tb_multimode_counter;

  localparam logic [1:0] MJ = 2'd0, MR = 2'd1, MB = 2'd2, MG = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = MJ;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q;
  logic       wrap;
  logic       illegal;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          stim_done = 1'b0;

  typedef struct {
    logic [3:0] q;
    logic       w;
    logic       i;
    string      tag;
  } exp_t;

  exp_t sb[$];

  multimode_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic ld, input logic e, input logic [1:0] md,
                      input logic d, input logic [3:0] lv, input logic [3:0] eq,
                      input logic ew, input logic ei, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; load = ld; en = e; mode = md; dir = d; load_val = lv;
    x.q = eq; x.w = ew; x.i = ei; x.tag = tag;
    sb.push_back(x);
  endtask

  // Monitor: every edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (q !== x.q) begin
          errors++;
          $display("FAIL %s q: got %b expected %b", x.tag, q, x.q);
        end
        checks++;
        if (wrap !== x.w) begin
          errors++;
          $display("FAIL %s wrap: got %b expected %b", x.tag, wrap, x.w);
        end
        checks++;
        if (illegal !== x.i) begin
          errors++;
          $display("FAIL %s illegal: got %b expected %b", x.tag, illegal, x.i);
        end
      end
    end
  end

  initial begin
    logic [3:0] jup[8]   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] jdn[8]   = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [3:0] rup[4]   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] gup[16]  = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                             4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    logic [3:0] prev;
    logic [3:0] diff;

    // Johnson up
    step(1, 0, 0, MJ, 0, '0, 4'b0000, 0, 0, "rst_j");
    for (int i = 0; i < 8; i++) step(0, 0, 1, MJ, 0, '0, jup[i], (i == 7), 0, "j_up");
    step(0, 0, 1, MJ, 0, '0, 4'b0001, 0, 0, "j_up_again");

    // Johnson down from seed
    step(1, 0, 0, MJ, 1, '0, 4'b0000, 0, 0, "rst_jd");
    for (int i = 0; i < 8; i++) step(0, 0, 1, MJ, 1, '0, jdn[i], (i == 0), 0, "j_dn");
    step(0, 0, 1, MJ, 1, '0, 4'b1000, 1, 0, "j_dn_wrap2");

    // hold: wrap drops, q stays
    for (int i = 0; i < 5; i++) step(0, 0, 0, MJ, 1, '0, 4'b1000, 0, 0, "hold");

    // Ring up, then illegal load and correction
    step(1, 0, 0, MR, 0, '0, 4'b0001, 0, 0, "rst_r");
    for (int i = 0; i < 4; i++) step(0, 0, 1, MR, 0, '0, rup[i], (i == 3), 0, "r_up");
    step(0, 1, 0, MR, 0, 4'b0110, 4'b0110, 0, 1, "r_load_bad");
    step(0, 0, 1, MR, 0, '0, 4'b0001, 0, 0, "r_correct");

    // Binary boundaries
    step(1, 0, 0, MB, 0, '0, 4'b0000, 0, 0, "rst_b");
    step(0, 0, 1, MB, 1, '0, 4'b1111, 1, 0, "b_dn_wrap");
    step(0, 0, 1, MB, 0, '0, 4'b0000, 1, 0, "b_up_wrap");
    step(0, 0, 1, MB, 0, '0, 4'b0001, 0, 0, "b_up");

    // Gray full cycle up, then down from seed
    step(1, 0, 0, MG, 0, '0, 4'b0000, 0, 0, "rst_g");
    for (int i = 0; i < 16; i++) step(0, 0, 1, MG, 0, '0, gup[i], (i == 15), 0, "g_up");
    step(0, 0, 1, MG, 1, '0, 4'b1000, 1, 0, "g_dn_wrap");

    // load beats en; correction to seed does not wrap
    step(1, 0, 0, MJ, 0, '0, 4'b0000, 0, 0, "rst_j2");
    step(0, 1, 1, MJ, 0, 4'b1010, 4'b1010, 0, 1, "load_en");
    step(0, 0, 1, MJ, 0, '0, 4'b0000, 0, 0, "j_correct");

    // reset on the edge that would have wrapped
    for (int i = 0; i < 7; i++) step(0, 0, 1, MJ, 0, '0, jup[i], 0, 0, "j_up2");
    step(1, 0, 1, MJ, 0, '0, 4'b0000, 0, 0, "rst_mid");

    // Johnson -> Ring switch with q=0011
    step(0, 0, 1, MJ, 0, '0, 4'b0001, 0, 0, "j_a");
    step(0, 0, 1, MJ, 0, '0, 4'b0011, 0, 0, "j_b");
    step(0, 0, 0, MR, 0, '0, 4'b0011, 0, 1, "switch_ring");
    step(0, 0, 1, MR, 0, '0, 4'b0001, 0, 0, "ring_correct");

    // Gray single-bit property checked directly over a second cycle
    step(1, 0, 0, MG, 0, '0, 4'b0000, 0, 0, "rst_g2");
    @(negedge clk);
    en = 1'b1; rst = 1'b0;
    prev = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      diff = q ^ prev;
      checks++;
      if ($countones(diff) != 1) begin
        errors++;
        $display("FAIL gray_onebit: got %b after %b, expected a single-bit change", q, prev);
      end
      prev = q;
    end
    @(negedge clk);
    en = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    int unsigned guard;
    wait (stim_done);
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multimode_counter.md
# multimode_counter

Parametrised successor to the team's fixed 4-bit Johnson counter: a WIDTH-bit counter register selectable at run time between Johnson (twisted-ring), one-hot ring, binary and Gray sequencing, with direction, enable, parallel load, illegal-state detection/self-correction and a wrap pulse. Used as a sequence/phase generator and as a drop-in replacement wherever the Johnson counter is instantiated (mode = Johnson, dir = up, en = 1, load = 0 reproduces it).

## Interface
- WIDTH, 4, counter width; legal range 2..32.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance one step this cycle.
- mode  in  2  0 = JOHNSON, 1 = RING, 2 = BINARY, 3 = GRAY.
- dir  in  1  0 = up/shift-left, 1 = down/shift-right.
- load  in  1  parallel load of load_val.
- load_val  in  WIDTH  value for load; not checked.
- q  out  WIDTH  counter state (registered).
- wrap  out  1  registered one-cycle pulse on a sequence wrap.
- illegal  out  1  combinational: q is not a legal state of the current mode.

## Operation
- Seed per mode: JOHNSON 0, RING 1 (bit 0 set), BINARY 0, GRAY 0.
- Priority per clock edge: rst > load > en > hold.
- rst: q <= seed(mode sampled in that cycle); wrap <= 0. After reset illegal = 0.
- load: q <= load_val regardless of en; wrap <= 0.
- en with illegal = 1: q <= seed(mode) (correction step); wrap <= 0.
- en with illegal = 0, next state:
  - JOHNSON up {q[W-2:0], ~q[W-1]}; down {~q[0], q[W-1:1]}; period 2·WIDTH.
  - RING up {q[W-2:0], q[W-1]}; down {q[0], q[W-1:1]}; period WIDTH.
  - BINARY q ± 1 mod 2^WIDTH.
  - GRAY bin2gray(gray2bin(q) ± 1) mod 2^WIDTH; one bit changes per step.
- Legality: JOHNSON legal iff popcount(q[W-1:1] ^ q[W-2:0]) ≤ 1; RING legal iff popcount(q) == 1; BINARY/GRAY always legal.
- wrap <= 1 after a normal enabled step where: up and next q == seed, or down and current q == seed. Else 0.
- mode/dir may change any cycle; take effect at that edge. A mode change leaving q illegal raises illegal immediately; the next enabled step corrects it.

## Timing
- q, wrap: one-cycle latency from sampled inputs; no pipelining, one step per enabled cycle.
- illegal: same-cycle function of q and mode; no registered state.
- Reset mid-count: q returns to seed on that edge; a pending wrap is cleared.
- load and en together: load wins, no step, no wrap.
- en = 0: q and illegal hold; wrap deasserts next edge.
- Correction step never pulses wrap even if the result is the seed.

## Structure
- Package multimode_counter_pkg: mode enum typedef (JOHNSON, RING, BINARY, GRAY), seed function, bin2gray/gray2bin functions, legality function.
- One sub-module, gray_step: combinational gray ± 1 next-state for WIDTH bits; everything else inline in multimode_counter.

## Test plan
- WIDTH=4, JOHNSON, up, en=1 after rst: q = 0000,0001,0011,0111,1111,1110,1100,1000,0000; wrap high exactly in the cycle q returns to 0000, every 8 cycles.
- JOHNSON down from 0000: 1000,1100,1110,1111,0111,0011,0001,0000; wrap pulses the cycle after leaving 0000.
- RING up after rst: 0001,0010,0100,1000,0001; load 0110 -> illegal=1 next cycle, next enabled edge q=0001, wrap=0.
- BINARY down from 0000 -> 1111 with wrap=1; GRAY up from 0000: 0001,0011,0010,0110,…, 1000, 0000, single-bit change each step, wrap at 0000.
- load=1 and en=1 with load_val=1010 in JOHNSON -> q=1010, illegal=1, wrap=0; rst asserted mid-sequence -> q=seed next edge, wrap=0.
- en=0 for 5 cycles mid-sequence -> q holds, wrap=0; switch JOHNSON→RING with q=0011 -> illegal=1 same cycle, corrected to 0001 on next en.
